// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, default geometry
// and the word returned for rejected (out-of-range) reads.
package mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 512;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word array: write-enable port and registered read.
// Contents are never reset.
module ram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit writes and register the read word on the same edge
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the MAR/MDR port. Accepts a single read or write
// from IDLE, waits WAIT_CYCLES+1 cycles, pulses mem_ready for one cycle and,
// for reads, drives mem_data from RESP until the read strobe drops.
// Optional feature macro: RAM_BOUNDS_CHECK_EN (addresses >= DEPTH complete
// normally but reads return zero, writes are dropped and mem_err pulses).
module ram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_read,
  input  logic              mem_write,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t             state, nstate;
  logic [CNT_W-1:0]   cnt;
  logic               is_rd_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               oob_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata;
  logic [DATA_W-1:0]  rd_word;
  logic               req;
  logic               start;
  logic               both;
  logic               commit;
  logic               drive;
  logic               unused_addr;

  // Upper address bits only matter to the bounds check; aliasing drops them.
  assign unused_addr = ^address;

  assign req    = is_rd_q ? mem_read : mem_write;
  assign start  = (state == IDLE) && (mem_read ^ mem_write);
  assign both   = (state == IDLE) && mem_read && mem_write;
  // Final WAIT cycle with the request still held: the edge entering RESP.
  assign commit = (state == WAIT) && req && (cnt == '0);

  // State register
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= nstate;
  end

  // Next state: the acceptance edge always lands in WAIT, which lasts
  // WAIT_CYCLES+1 cycles, so completion follows the sampled request by
  // WAIT_CYCLES+1 edges even when WAIT_CYCLES is 0.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = WAIT;
      WAIT:    if (!req) nstate = IDLE;
               else if (cnt == '0) nstate = RESP;
      RESP:    nstate = HOLD;
      HOLD:    if (!req) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Wait-state counter, loaded on acceptance and run down inside WAIT
  always_ff @(posedge clock) begin
    if (clear)                           cnt <= '0;
    else if (start)                      cnt <= CNT_W'(WAIT_CYCLES);
    else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
  end

  // Latch direction, word index and write data once per accepted request
  always_ff @(posedge clock) begin
    if (start) begin
      is_rd_q <= mem_read;
      idx_q   <= address[IDX_W-1:0];
      wdata_q <= mem_data;
    end
  end

`ifdef RAM_BOUNDS_CHECK_EN
  // Flag an out-of-range access at acceptance; it still completes normally
  always_ff @(posedge clock) begin
    if (start) oob_q <= (32'(address) >= 32'(DEPTH));
  end
`else
  assign oob_q = 1'b0;
`endif

  // Simultaneous-strobe error, pulsed for the cycle after the offending edge
  always_ff @(posedge clock) begin
    if (clear) err_q <= 1'b0;
    else       err_q <= both;
  end

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (commit && !is_rd_q && !oob_q),
    .re    (commit && is_rd_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign rd_word   = oob_q ? DATA_W'(ZERO_WORD) : rdata;
  assign drive     = is_rd_q && (state == RESP || state == HOLD);
  assign mem_data  = drive ? rd_word : {DATA_W{1'bz}};
  assign mem_ready = (state == RESP);
  assign mem_err   = err_q || ((state == RESP) && oob_q);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances with 1, 0 and 3 wait states share
// one clock and clear. Directed scenarios followed by random reads/writes,
// all compared against a per-instance word-array reference model.
module tb_ram_responder;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int DEP = 256;
  localparam int NCH = 3;

  function automatic int wait_of(input int c);
    return (c == 0) ? 1 : (c == 1) ? 0 : 3;
  endfunction

  logic          clock = 1'b0;
  logic          clear;
  logic          rd   [NCH];
  logic          wr   [NCH];
  logic          drv  [NCH];
  logic [AW-1:0] addr [NCH];
  logic [DW-1:0] wdat [NCH];
  wire           ready_s [NCH];
  wire           err_s   [NCH];
  wire  [DW-1:0] bus_s   [NCH];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    wire [DW-1:0] bus;
    assign bus      = drv[g] ? wdat[g] : {DW{1'bz}};
    assign bus_s[g] = bus;
    ram_responder #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .DEPTH       (DEP),
      .WAIT_CYCLES (wait_of(g))
    ) dut (
      .clock     (clock),
      .clear     (clear),
      .address   (addr[g]),
      .mem_read  (rd[g]),
      .mem_write (wr[g]),
      .mem_data  (bus),
      .mem_ready (ready_s[g]),
      .mem_err   (err_s[g])
    );
  end

  // Reference model: plain word arrays plus a "has been written" flag
  logic [DW-1:0] model [NCH][DEP];
  bit            known [NCH][DEP];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef RAM_BOUNDS_CHECK_EN
    return int'(a) >= DEP;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit released(input logic [DW-1:0] v);
    return $isunknown(v) || (v == '0);
  endfunction

  // One complete access; abort_at >= 0 drops the strobe after that sample
  task automatic access(input int c, input bit is_wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int abort_at, input string tag);
    int            w;
    int            ix;
    bit            oob;
    bit            gone;
    bit            exp_rdy;
    bit            data_known;
    logic [DW-1:0] exp_rd;
    w          = wait_of(c);
    ix         = int'(a) % DEP;
    oob        = is_oob(a);
    gone       = 1'b0;
    exp_rd     = oob ? '0 : model[c][ix];
    data_known = oob || known[c][ix];
    addr[c] = a;
    if (is_wr) begin
      wr[c] = 1'b1; wdat[c] = d; drv[c] = 1'b1;
    end else begin
      rd[c] = 1'b1;
    end
    @(negedge clock);
    addr[c] = AW'($urandom);
    for (int n = 0; n <= w + 2; n++) begin
      if (n > 0) @(negedge clock);
      exp_rdy = !gone && (n == w + 1);
      check_val($sformatf("%s.ready.n%0d", tag, n), {31'b0, ready_s[c]}, {31'b0, exp_rdy});
      check_val($sformatf("%s.err.n%0d", tag, n), {31'b0, err_s[c]}, {31'b0, exp_rdy && oob});
      if (!is_wr) begin
        if (!gone && n >= w + 1) begin
          if (data_known)
            check_val($sformatf("%s.rdata.n%0d", tag, n), bus_s[c], exp_rd);
        end else begin
          check_val($sformatf("%s.hiz.n%0d", tag, n), {31'b0, released(bus_s[c])}, 32'd1);
        end
      end
      if (n == abort_at) begin
        rd[c] = 1'b0; wr[c] = 1'b0; drv[c] = 1'b0; gone = 1'b1;
      end
    end
    rd[c] = 1'b0; wr[c] = 1'b0; drv[c] = 1'b0;
    @(negedge clock);
    check_val({tag, ".idle.ready"}, {31'b0, ready_s[c]}, 32'd0);
    check_val({tag, ".idle.hiz"}, {31'b0, released(bus_s[c])}, 32'd1);
    if (is_wr && !gone && !oob) begin
      model[c][ix] = d;
      known[c][ix] = 1'b1;
    end
  endtask

  task automatic both_strobes(input int c);
    addr[c] = AW'($urandom);
    rd[c] = 1'b1; wr[c] = 1'b1;
    @(negedge clock);
    check_val("both.err", {31'b0, err_s[c]}, 32'd1);
    check_val("both.ready", {31'b0, ready_s[c]}, 32'd0);
    rd[c] = 1'b0; wr[c] = 1'b0;
    @(negedge clock);
    check_val("both.err_clr", {31'b0, err_s[c]}, 32'd0);
    check_val("both.ready2", {31'b0, ready_s[c]}, 32'd0);
  endtask

  task automatic clear_mid_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[c] = a; wr[c] = 1'b1; wdat[c] = d; drv[c] = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check_val("clr.ready", {31'b0, ready_s[c]}, 32'd0);
    check_val("clr.err", {31'b0, err_s[c]}, 32'd0);
    clear = 1'b0; wr[c] = 1'b0; drv[c] = 1'b0;
    for (int n = 0; n < wait_of(c) + 3; n++) begin
      @(negedge clock);
      check_val($sformatf("clr.post.ready.n%0d", n), {31'b0, ready_s[c]}, 32'd0);
      check_val($sformatf("clr.post.hiz.n%0d", n), {31'b0, released(bus_s[c])}, 32'd1);
    end
  endtask

  initial begin
    bit            w_r;
    int            c;
    int            ab;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < NCH; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; drv[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
      for (int j = 0; j < DEP; j++) begin
        model[i][j] = '0; known[i][j] = 1'b0;
      end
    end
    clear = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < NCH; i++) begin
      check_val($sformatf("rst.ready%0d", i), {31'b0, ready_s[i]}, 32'd0);
      check_val($sformatf("rst.err%0d", i), {31'b0, err_s[i]}, 32'd0);
      check_val($sformatf("rst.hiz%0d", i), {31'b0, released(bus_s[i])}, 32'd1);
    end
    clear = 1'b0;
    @(negedge clock);

    // One wait state: basic write/read and reverse-order readback
    access(0, 1'b1, 9'd0, 32'h2891_8000, -1, "w0");
    access(0, 1'b0, 9'd0, '0, -1, "r0");
    access(0, 1'b1, 9'd2, 32'h12, -1, "w2");
    access(0, 1'b1, 9'd3, 32'h14, -1, "w3");
    access(0, 1'b1, 9'd1, 32'h18, -1, "w1");
    access(0, 1'b0, 9'd1, '0, -1, "r1");
    access(0, 1'b0, 9'd3, '0, -1, "r3");
    access(0, 1'b0, 9'd2, '0, -1, "r2");

    // Zero wait states
    access(1, 1'b1, 9'd3, 32'h14, -1, "z.w3");
    access(1, 1'b0, 9'd3, '0, -1, "z.r3");

    // Three wait states: aborted write leaves the old word
    access(2, 1'b1, 9'd5, 32'hCAFE_0005, -1, "a.w5");
    access(2, 1'b1, 9'd5, 32'hDEAD_BEEF, 1, "a.abort");
    access(2, 1'b0, 9'd5, '0, -1, "a.r5");

    // Simultaneous strobes, then a normal access still completes
    both_strobes(0);
    access(0, 1'b0, 9'd0, '0, -1, "both.r0");

    // Clear in the middle of a write
    clear_mid_write(2, 9'd5, 32'h5555_5555);
    access(2, 1'b0, 9'd5, '0, -1, "clr.r5");

    // Address 300: out of range when bounds-checked, aliases to 44 otherwise
    access(0, 1'b1, 9'd300, 32'hA5A5_0300, -1, "b.w300");
    access(0, 1'b0, 9'd300, '0, -1, "b.r300");
    access(0, 1'b0, 9'd44, '0, -1, "b.r44");

    // Random traffic across all three instances
    for (int t = 0; t < 80; t++) begin
      c   = int'($urandom_range(0, NCH - 1));
      w_r = 1'($urandom_range(0, 1));
      a   = AW'($urandom);
      d   = $urandom | 32'h1;
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, wait_of(c))) : -1;
      if ($urandom_range(0, 9) == 0) both_strobes(c);
      access(c, w_r, a, d, ab, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
